// File: rtl/nes_pad_receiver.sv
// Serial NES/SNES gamepad receiver: drives latch/clock to NUM_PADS pads, shifts in BUTTONS bits each.
// Optional macro NES_DEBOUNCE_EN: a bit only changes when two consecutive reads agree.
module nes_pad_receiver #(
    parameter int NUM_PADS = 1,
    parameter int BUTTONS  = 8,
    parameter int CLK_DIV  = 150
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         poll,
    input  logic [NUM_PADS-1:0]          pad_data,
    output logic                         pad_latch,
    output logic                         pad_clk,
    output logic [NUM_PADS*BUTTONS-1:0]  buttons,
    output logic [NUM_PADS*BUTTONS-1:0]  pressed,
    output logic                         valid,
    output logic                         busy
);
    localparam int W     = NUM_PADS * BUTTONS;
    localparam int DIV_W = $clog2(2 * CLK_DIV);
    localparam int IDX_W = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;

    localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(BUTTONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_GAP,
        S_CLK_HI,
        S_CLK_LO,
        S_DONE
    } state_t;

    state_t              state, state_next;
    logic [NUM_PADS-1:0] sync1, sync2;
    logic [DIV_W-1:0]    div;
    logic [IDX_W-1:0]    bit_idx;
    logic [W-1:0]        raw, raw_next, fresh, btn_next;
    logic                div_last, sample_en;
`ifdef NES_DEBOUNCE_EN
    logic [W-1:0]        prev_fresh;
`endif

    // Released pads pull high, so the synchroniser resets to all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= pad_data;
            sync2 <= sync1;
        end
    end

    assign div_last  = (state == S_LATCH) ? (div == LATCH_LAST) : (div == HALF_LAST);
    assign sample_en = div_last && (state == S_GAP || state == S_CLK_LO);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (poll) state_next = S_LATCH;
            S_LATCH:  if (div_last) state_next = S_GAP;
            S_GAP:    if (div_last) state_next = (BUTTONS > 1) ? S_CLK_HI : S_DONE;
            S_CLK_HI: if (div_last) state_next = S_CLK_LO;
            S_CLK_LO: if (div_last) state_next = (bit_idx == IDX_LAST) ? S_DONE : S_CLK_HI;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // bit_idx always names the next bit to capture, so GAP and CLK_LO share one sample path.
    always_comb begin
        raw_next = raw;
        if (sample_en) begin
            for (int p = 0; p < NUM_PADS; p++) begin
                raw_next[p * BUTTONS + int'(bit_idx)] = sync2[p];
            end
        end
        fresh = ~raw_next;
`ifdef NES_DEBOUNCE_EN
        btn_next = (fresh & ~(fresh ^ prev_fresh)) | (buttons & (fresh ^ prev_fresh));
`else
        btn_next = fresh;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            div       <= '0;
            bit_idx   <= '0;
            raw       <= '0;
            pad_latch <= 1'b0;
            pad_clk   <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            buttons   <= '0;
            pressed   <= '0;
`ifdef NES_DEBOUNCE_EN
            prev_fresh <= '0;
`endif
        end else begin
            state <= state_next;
            div   <= (state_next != state || state == S_IDLE) ? '0 : div + DIV_W'(1);
            raw   <= raw_next;

            if (state == S_IDLE)
                bit_idx <= '0;
            else if (sample_en && bit_idx != IDX_LAST)
                bit_idx <= bit_idx + IDX_W'(1);

            // Outputs are registered from the next state so the pad lines never glitch.
            pad_latch <= (state_next == S_LATCH);
            pad_clk   <= (state_next == S_CLK_HI);
            busy      <= (state_next != S_IDLE);
            valid     <= (state_next == S_DONE);

            if (state_next == S_DONE) begin
                buttons <= btn_next;
                pressed <= btn_next & ~buttons;
`ifdef NES_DEBOUNCE_EN
                prev_fresh <= fresh;
`endif
            end else begin
                pressed <= '0;
            end
        end
    end
endmodule
